// File: rtl/udp_panel_reader.sv
// Reads a range of framebuffer pixels and streams them as UDP payload bytes,
// one 4-byte word {addr,R,G,B} per pixel. Optional macro: PANEL_READ_SEQ_EN (per-packet seq/count header).
module udp_panel_reader #(
  parameter logic [15:0] SRC_PORT       = 16'd6001,
  parameter int unsigned PIXELS_PER_PKT = 256,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] start_addr,
  input  logic [14:0] pixel_count,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  output logic        busy,
  output logic        done,
  output logic        fb_rd_en,
  output logic [13:0] fb_rd_addr,
  input  logic [23:0] fb_rd_data,
  output logic        udp_sink_valid,
  output logic        udp_sink_last,
  input  logic        udp_sink_ready,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data
);

  localparam int unsigned AW = 14;
  localparam int unsigned CW = 15;
  localparam int unsigned LW = 3;
  localparam logic [CW-1:0] PPP_W   = CW'(PIXELS_PER_PKT);
  localparam logic [LW-1:0] LAT_END = LW'(RD_LATENCY - 1);
`ifdef PANEL_READ_SEQ_EN
  localparam logic [15:0] HDR_BYTES = 16'd4;
`else
  localparam logic [15:0] HDR_BYTES = 16'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PKT, S_HDR, S_FETCH, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] pkt_left_q, pkt_left_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [LW-1:0] wait_cnt_q, wait_cnt_d;
  logic          busy_d, done_d, fb_rd_en_d, valid_d, last_d;
  logic [AW-1:0] fb_rd_addr_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   length_d;
  logic [31:0]   ip_d;
  logic [15:0]   port_d;
  logic [CW-1:0] n_pkt;
  logic [31:0]   pix_word;
  logic          beat_xfer;
  logic          unused_pad;
`ifdef PANEL_READ_SEQ_EN
  logic [15:0]   seq_q, seq_d;
`endif

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  // Pad bits of the framebuffer word carry no information.
  assign unused_pad = ^{fb_rd_data[23:22], fb_rd_data[15:14], fb_rd_data[7:6]};

  assign udp_sink_src_port = SRC_PORT;
  assign udp_sink_data     = {24'b0, data_q};
  assign beat_xfer         = udp_sink_valid & udp_sink_ready;
  assign n_pkt             = (remaining_q > PPP_W) ? PPP_W : remaining_q;
  assign pix_word          = {addr_q, fb_rd_data[21:16], fb_rd_data[13:8], fb_rd_data[5:0]};

  // State and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= S_IDLE;
      addr_q              <= '0;
      remaining_q         <= '0;
      pkt_left_q          <= '0;
      word_q              <= '0;
      byte_idx_q          <= '0;
      wait_cnt_q          <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      fb_rd_en            <= 1'b0;
      fb_rd_addr          <= '0;
      udp_sink_valid      <= 1'b0;
      udp_sink_last       <= 1'b0;
      data_q              <= '0;
      udp_sink_length     <= '0;
      udp_sink_ip_address <= '0;
      udp_sink_dst_port   <= '0;
`ifdef PANEL_READ_SEQ_EN
      seq_q               <= '0;
`endif
    end else begin
      state_q             <= state_d;
      addr_q              <= addr_d;
      remaining_q         <= remaining_d;
      pkt_left_q          <= pkt_left_d;
      word_q              <= word_d;
      byte_idx_q          <= byte_idx_d;
      wait_cnt_q          <= wait_cnt_d;
      busy                <= busy_d;
      done                <= done_d;
      fb_rd_en            <= fb_rd_en_d;
      fb_rd_addr          <= fb_rd_addr_d;
      udp_sink_valid      <= valid_d;
      udp_sink_last       <= last_d;
      data_q              <= data_d;
      udp_sink_length     <= length_d;
      udp_sink_ip_address <= ip_d;
      udp_sink_dst_port   <= port_d;
`ifdef PANEL_READ_SEQ_EN
      seq_q               <= seq_d;
`endif
    end
  end

  // Next state and next register values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    pkt_left_d   = pkt_left_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    wait_cnt_d   = wait_cnt_q;
    busy_d       = busy;
    done_d       = 1'b0;
    fb_rd_en_d   = 1'b0;
    fb_rd_addr_d = fb_rd_addr;
    valid_d      = udp_sink_valid;
    last_d       = udp_sink_last;
    data_d       = data_q;
    length_d     = udp_sink_length;
    ip_d         = udp_sink_ip_address;
    port_d       = udp_sink_dst_port;
`ifdef PANEL_READ_SEQ_EN
    seq_d        = seq_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pixel_count != '0) begin
            addr_d      = start_addr;
            remaining_d = pixel_count;
            ip_d        = dst_ip;
            port_d      = dst_port;
            busy_d      = 1'b1;
            state_d     = S_PKT;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_PKT: begin
        pkt_left_d = n_pkt;
        length_d   = 16'({n_pkt, 2'b00}) + HDR_BYTES;
`ifdef PANEL_READ_SEQ_EN
        word_d     = {seq_q, 16'(n_pkt)};
        byte_idx_d = 2'd0;
        valid_d    = 1'b1;
        data_d     = seq_q[15:8];
        state_d    = S_HDR;
`else
        fb_rd_en_d   = 1'b1;
        fb_rd_addr_d = addr_q;
        state_d      = S_FETCH;
`endif
      end

`ifdef PANEL_READ_SEQ_EN
      S_HDR: begin
        if (beat_xfer) begin
          if (byte_idx_q == 2'd3) begin
            valid_d      = 1'b0;
            seq_d        = seq_q + 16'd1;
            fb_rd_en_d   = 1'b1;
            fb_rd_addr_d = addr_q;
            state_d      = S_FETCH;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            data_d     = byte_of(word_q, byte_idx_q + 2'd1);
          end
        end
      end
`endif

      S_FETCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q == LAT_END) begin
          word_d     = pix_word;
          byte_idx_d = 2'd0;
          valid_d    = 1'b1;
          data_d     = pix_word[31:24];
          state_d    = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + LW'(1);
        end
      end

      S_SEND: begin
        if (beat_xfer) begin
          if (byte_idx_q == 2'd3) begin
            valid_d     = 1'b0;
            last_d      = 1'b0;
            addr_d      = addr_q + AW'(1);
            remaining_d = remaining_q - CW'(1);
            pkt_left_d  = pkt_left_q - CW'(1);
            if (pkt_left_q != CW'(1)) begin
              fb_rd_en_d   = 1'b1;
              fb_rd_addr_d = addr_q + AW'(1);
              state_d      = S_FETCH;
            end else if (remaining_q != CW'(1)) begin
              state_d = S_PKT;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            data_d     = byte_of(word_q, byte_idx_q + 2'd1);
            last_d     = (byte_idx_q == 2'd2) && (pkt_left_q == CW'(1));
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_panel_reader.sv
// Directed self-checking bench for udp_panel_reader; follows PANEL_READ_SEQ_EN if defined.
module tb_udp_panel_reader;

  localparam int unsigned PPP = 256;
`ifdef PANEL_READ_SEQ_EN
  localparam int unsigned HDR = 4;
  logic [15:0] tb_seq;
`else
  localparam int unsigned HDR = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] start_addr;
  logic [14:0] pixel_count;
  logic [31:0] dst_ip;
  logic [15:0] dst_port;
  logic        busy, done, fb_rd_en;
  logic [13:0] fb_rd_addr;
  logic [23:0] fb_rd_data;
  logic        udp_sink_valid, udp_sink_last, udp_sink_ready;
  logic [15:0] udp_sink_src_port, udp_sink_dst_port, udp_sink_length;
  logic [31:0] udp_sink_ip_address, udp_sink_data;

  udp_panel_reader #(.SRC_PORT(16'd6001), .PIXELS_PER_PKT(PPP), .RD_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .pixel_count(pixel_count), .dst_ip(dst_ip), .dst_port(dst_port),
    .busy(busy), .done(done), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data), .udp_sink_valid(udp_sink_valid), .udp_sink_last(udp_sink_last),
    .udp_sink_ready(udp_sink_ready), .udp_sink_src_port(udp_sink_src_port),
    .udp_sink_dst_port(udp_sink_dst_port), .udp_sink_ip_address(udp_sink_ip_address),
    .udp_sink_length(udp_sink_length), .udp_sink_data(udp_sink_data)
  );

  int vectors, miscompares;
  int done_cnt, stall_viol, field_viol;
  bit bp_en;
  logic [31:0] cur_ip;
  logic [15:0] cur_port;
  logic [7:0]  got_byte[$];
  bit          got_last[$];
  logic [15:0] last_lens[$];
  logic [7:0]  exp_byte[$];
  bit          exp_last[$];
  logic [15:0] exp_lens[$];
  bit          prev_stall;
  logic [7:0]  prev_data;
  logic        prev_last;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [23:0] fb_pix(input logic [13:0] a);
    if (a == 14'h0123) return {2'b0, 6'h3F, 2'b0, 6'h00, 2'b0, 6'h15};
    return {2'b0, a[5:0], 2'b0, a[11:6] ^ 6'h15, 2'b0, a[13:12], a[3:0]};
  endfunction

  // Framebuffer model, one-cycle read latency.
  always @(posedge clock) if (fb_rd_en) fb_rd_data <= fb_pix(fb_rd_addr);

  always @(posedge clock) begin
    #1;
    udp_sink_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat collector and handshake-stability monitor.
  always @(negedge clock) begin
    if (prev_stall && (udp_sink_valid !== 1'b1 || udp_sink_data[7:0] !== prev_data ||
                       udp_sink_last !== prev_last))
      stall_viol++;
    if (udp_sink_valid === 1'b1 && udp_sink_ready === 1'b1) begin
      got_byte.push_back(udp_sink_data[7:0]);
      got_last.push_back(udp_sink_last);
      if (udp_sink_last) last_lens.push_back(udp_sink_length);
      if (udp_sink_data[31:8] !== 24'b0 || udp_sink_src_port !== 16'd6001 ||
          udp_sink_dst_port !== cur_port || udp_sink_ip_address !== cur_ip)
        field_viol++;
    end
    prev_stall = udp_sink_valid && !udp_sink_ready;
    prev_data  = udp_sink_data[7:0];
    prev_last  = udp_sink_last;
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_obs();
    got_byte.delete(); got_last.delete(); last_lens.delete();
    exp_byte.delete(); exp_last.delete(); exp_lens.delete();
    done_cnt = 0; stall_viol = 0; field_viol = 0;
  endtask

  task automatic build_exp(input logic [13:0] a0, input int cnt);
    logic [13:0] a;
    logic [31:0] w;
    int rem, n;
    a = a0; rem = cnt;
    while (rem > 0) begin
      n = (rem > PPP) ? PPP : rem;
`ifdef PANEL_READ_SEQ_EN
      w = {tb_seq, 16'(n)};
      for (int b = 0; b < 4; b++) begin
        exp_byte.push_back(w[31-8*b -: 8]);
        exp_last.push_back(1'b0);
      end
      tb_seq = tb_seq + 16'd1;
`endif
      for (int i = 0; i < n; i++) begin
        w = {a, fb_pix(a)[21:16], fb_pix(a)[13:8], fb_pix(a)[5:0]};
        for (int b = 0; b < 4; b++) begin
          exp_byte.push_back(w[31-8*b -: 8]);
          exp_last.push_back(b == 3 && i == n - 1);
        end
        a = a + 14'd1;
      end
      exp_lens.push_back(16'(4 * n + HDR));
      rem -= n;
    end
  endtask

  function automatic int first_diff();
    int m;
    m = (got_byte.size() < exp_byte.size()) ? got_byte.size() : exp_byte.size();
    for (int i = 0; i < m; i++)
      if (got_byte[i] !== exp_byte[i] || got_last[i] !== exp_last[i]) return i;
    return (got_byte.size() == exp_byte.size()) ? -1 : m;
  endfunction

  task automatic do_start(input logic [13:0] a, input int cnt, input logic [31:0] ip,
                          input logic [15:0] port);
    cur_ip = ip; cur_port = port;
    start_addr = a; pixel_count = 15'(cnt); dst_ip = ip; dst_port = port;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin timed_out = 1'b0; break; end
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    logic [31:0] v [10];
    logic [31:0] w [10];
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    v = '{32'(busy), 32'(done), 32'(fb_rd_en), 32'(fb_rd_addr), 32'(udp_sink_valid),
          32'(udp_sink_last), udp_sink_data, 32'(udp_sink_length), udp_sink_ip_address,
          32'(udp_sink_dst_port)};
    w = '{default: 32'd0};
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (v[i] !== w[i]) begin
        miscompares++;
        $display("FAIL reset_out%0d: got %h want %h", i, v[i], w[i]);
      end
    end
    // start together with reset must be ignored
    start_addr = 14'h0010; pixel_count = 15'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_wins_start: busy %b want 0", busy);
    end
    reset = 1'b0;
`ifdef PANEL_READ_SEQ_EN
    tb_seq = 16'd0;
`endif
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int k, d;
    bit to;
    logic [31:0] pw;
    clear_obs();
    build_exp(14'h0123, 1);
    cur_ip = 32'hC0A8_0102; cur_port = 16'd7000;
    start_addr = 14'h0123; pixel_count = 15'd1; dst_ip = cur_ip; dst_port = cur_port;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (udp_sink_valid !== 1'b1 && k < 50) begin @(negedge clock); k++; end
    vectors++;
    if (k !== ((HDR != 0) ? 2 : 4)) begin
      miscompares++; $display("FAIL single_latency: got %0d want %0d", k, (HDR != 0) ? 2 : 4);
    end
    wait_done(200, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL single_done_timeout: got 1 want 0"); end
    d = first_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL single_stream: diff at beat %0d, got %0d beats want %0d", d,
               got_byte.size(), exp_byte.size());
    end
    pw = (got_byte.size() == 4 + HDR) ?
         {got_byte[HDR], got_byte[HDR+1], got_byte[HDR+2], got_byte[HDR+3]} : 32'hx;
    vectors++;
    if (pw !== 32'h048F_F015) begin
      miscompares++; $display("FAIL single_word: got %h want 048ff015", pw);
    end
    vectors++;
    if (last_lens.size() !== 1 || last_lens[0] !== 16'(4 + HDR)) begin
      miscompares++; $display("FAIL single_length: got %0d lasts want 1 at length %0d",
                              last_lens.size(), 4 + HDR);
    end
    vectors++;
    if (busy !== 1'b0 || done_cnt !== 1 || field_viol !== 0) begin
      miscompares++; $display("FAIL single_status: busy %b done_cnt %0d field_viol %0d want 0/1/0",
                              busy, done_cnt, field_viol);
    end
  endtask

  task automatic test_multi_packet();
    int d;
    bit to;
    clear_obs();
    build_exp(14'h0100, 600);
    do_start(14'h0100, 600, 32'h0A00_0001, 16'd7001);
    wait_done(20000, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL multi_done_timeout: got 1 want 0"); end
    d = first_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL multi_stream: diff at beat %0d, got %0d beats want %0d", d,
               got_byte.size(), exp_byte.size());
    end
    vectors++;
    if (last_lens.size() !== 3) begin
      miscompares++; $display("FAIL multi_last_count: got %0d want 3", last_lens.size());
    end else begin
      vectors++;
      if (last_lens[0] !== 16'(1024 + HDR) || last_lens[1] !== 16'(1024 + HDR) ||
          last_lens[2] !== 16'(352 + HDR)) begin
        miscompares++;
        $display("FAIL multi_lengths: got %0d/%0d/%0d want %0d/%0d/%0d", last_lens[0],
                 last_lens[1], last_lens[2], 1024 + HDR, 1024 + HDR, 352 + HDR);
      end
    end
  endtask

  task automatic test_backpressure();
    int d;
    bit to;
    clear_obs();
    build_exp(14'h2000, 40);
    bp_en = 1'b1;
    do_start(14'h2000, 40, 32'h0A00_0002, 16'd7002);
    wait_done(5000, to);
    bp_en = 1'b0;
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL bp_done_timeout: got 1 want 0"); end
    d = first_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL bp_stream: diff at beat %0d, got %0d beats want %0d", d,
               got_byte.size(), exp_byte.size());
    end
    vectors++;
    if (stall_viol !== 0 || field_viol !== 0) begin
      miscompares++;
      $display("FAIL bp_stable: stall_viol %0d field_viol %0d want 0/0", stall_viol, field_viol);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] want [4];
    logic [13:0] a;
    bit to;
    int d;
    want = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    clear_obs();
    build_exp(14'h3FFE, 4);
    do_start(14'h3FFE, 4, 32'h0A00_0003, 16'd7003);
    wait_done(500, to);
    d = first_diff();
    vectors++;
    if (to !== 1'b0 || d !== -1) begin
      miscompares++;
      $display("FAIL wrap_stream: timeout %b diff %0d want 0/-1", to, d);
    end
    for (int p = 0; p < 4; p++) begin
      a = (got_byte.size() == 16 + HDR) ?
          {got_byte[HDR+4*p], got_byte[HDR+4*p+1][7:2]} : 14'hx;
      vectors++;
      if (a !== want[p]) begin
        miscompares++; $display("FAIL wrap_addr%0d: got %h want %h", p, a, want[p]);
      end
    end
  endtask

  task automatic test_zero_and_ignore();
    bit to;
    int d;
    clear_obs();
    do_start(14'h0050, 0, 32'h0A00_0004, 16'd7004);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL zero_done: done %b busy %b want 1/0", done, busy);
    end
    @(posedge clock); #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    repeat (4) @(posedge clock);
    #1;
    vectors++;
    if (got_byte.size() !== 0) begin
      miscompares++; $display("FAIL zero_no_beats: got %0d want 0", got_byte.size());
    end
    clear_obs();
    build_exp(14'h0010, 3);
    do_start(14'h0010, 3, 32'h0A00_0005, 16'd7005);
    repeat (3) @(posedge clock);
    #1;
    start_addr = 14'h0500; pixel_count = 15'd7; dst_ip = 32'hDEAD_BEEF; dst_port = 16'd1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(500, to);
    repeat (60) @(posedge clock);
    #1;
    d = first_diff();
    vectors++;
    if (to !== 1'b0 || d !== -1 || done_cnt !== 1 || field_viol !== 0) begin
      miscompares++;
      $display("FAIL busy_start_ignored: timeout %b diff %0d done_cnt %0d field_viol %0d want 0/-1/1/0",
               to, d, done_cnt, field_viol);
    end
  endtask

  task automatic test_reset_mid();
    int k, n_at_reset;
    clear_obs();
    do_start(14'h0040, 10, 32'h0A00_0006, 16'd7006);
    k = 0;
    while (udp_sink_valid !== 1'b1 && k < 50) begin @(posedge clock); #1; k++; end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_at_reset = got_byte.size();
    vectors++;
    if (k >= 50 || udp_sink_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: valid %b busy %b done %b waited %0d want 0/0/0 <50",
               udp_sink_valid, busy, done, k);
    end
    reset = 1'b0;
`ifdef PANEL_READ_SEQ_EN
    tb_seq = 16'd0;
`endif
    repeat (30) @(posedge clock);
    #1;
    vectors++;
    if (done_cnt !== 0 || got_byte.size() !== n_at_reset) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: done_cnt %0d beats %0d want 0/%0d", done_cnt,
               got_byte.size(), n_at_reset);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int d;
    logic [31:0] hw [2];
    hw = '{32'h0000_0003, 32'h0001_0003};
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      build_exp(r == 0 ? 14'h0001 : 14'h0200, 3);
      do_start(r == 0 ? 14'h0001 : 14'h0200, 3, 32'h0A00_0010, 16'd6000);
      wait_done(500, to);
      d = first_diff();
      vectors++;
      if (to !== 1'b0 || d !== -1) begin
        miscompares++; $display("FAIL b2b_stream%0d: timeout %b diff %0d want 0/-1", r, to, d);
      end
      vectors++;
      if (last_lens.size() !== 1 || last_lens[0] !== 16'(12 + HDR)) begin
        miscompares++;
        $display("FAIL b2b_length%0d: got %0d lasts want 1 at length %0d", r, last_lens.size(),
                 12 + HDR);
      end
`ifdef PANEL_READ_SEQ_EN
      vectors++;
      if (got_byte.size() < 4 ||
          {got_byte[0], got_byte[1], got_byte[2], got_byte[3]} !== hw[r]) begin
        miscompares++; $display("FAIL b2b_header%0d: wrong header, want %h", r, hw[r]);
      end
`else
      vectors++;
      if (got_byte.size() < 1 || got_byte[0] === hw[r][31:24] + 8'hFF) begin
        miscompares++; $display("FAIL b2b_first_byte%0d: got %0d beats", r, got_byte.size());
      end
`endif
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    bp_en = 1'b0; udp_sink_ready = 1'b1; prev_stall = 1'b0;
    reset = 1'b1; start = 1'b0; start_addr = '0; pixel_count = '0;
    dst_ip = '0; dst_port = '0; cur_ip = '0; cur_port = '0; fb_rd_data = '0;
    clear_obs();
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_multi_packet();
    test_backpressure();
    test_wrap();
    test_zero_and_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
